// File: rtl/seg7_result_scanner_pkg.sv
// Shared constants for the 7-segment result display path.
// Blank levels and the active-low hex segment table {g,f,e,d,c,b,a}.
package seg7_result_scanner_pkg;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic       DP_OFF  = 1'b1;

    // Element [n] is the segment pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_result_scanner_hex_to_seg7.sv
// Hex nibble to active-low 7-segment pattern.
// Purely combinational; shared with other display stages.
module hex_to_seg7
    import seg7_result_scanner_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_result_scanner.sv
// Captures the CPU result word and flags and scans them out
// as eight hex digits with flags on the decimal points.
module seg7_result_scanner
    import seg7_result_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Data,
    input  logic        ZF,
    input  logic        OF,
    input  logic        Load,
    input  logic        Freeze,
    input  logic        Blank_Lz,
    output logic        Ack,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] TC = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BL = PW'(BLANK_CYC);

    logic [31:0]   shadow;
    logic          zf_q;
    logic          of_q;
    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          cap;
    logic          tc;
    logic [3:0]    nib;
    logic [6:0]    dec;
    logic          zrun;
    logic          lz_blank;
    logic [7:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    assign cap = Load & ~Freeze;
    assign tc  = (presc == TC);
    assign nib = shadow[{idx, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nib (nib),
        .seg (dec)
    );

    // Capture the result word and flags; Ack mirrors the capture.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            shadow <= '0;
            zf_q   <= 1'b0;
            of_q   <= 1'b0;
            Ack    <= 1'b0;
        end else begin
            Ack <= cap;
            if (cap) begin
                shadow <= Data;
                zf_q   <= ZF;
                of_q   <= OF;
            end
        end
    end

    // Slot prescaler and digit index; index advances on wrap.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            presc <= '0;
            idx   <= 3'd0;
        end else if (tc) begin
            presc <= '0;
            idx   <= idx + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Detect that the current digit and every higher one are zero.
    always_comb begin
        zrun = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) >= idx && shadow[4*i +: 4] != 4'h0) begin
                zrun = 1'b0;
            end
        end
        lz_blank = Blank_Lz && (idx != 3'd0) && zrun;
    end

    // Next display outputs from the current scan position.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        if (presc >= BL && !lz_blank) begin
            an_d  = ~(8'b1 << idx);
            seg_d = dec;
            unique case (1'b1)
                idx == 3'd7: dp_d = ~of_q;
                idx == 3'd6: dp_d = ~zf_q;
                default:     dp_d = DP_OFF;
            endcase
        end
    end

    // Register the pins so they change glitch-free once per cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            AN  <= AN_OFF;
            SEG <= SEG_OFF;
            DP  <= DP_OFF;
        end else begin
            AN  <= an_d;
            SEG <= seg_d;
            DP  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_result_scanner.sv
// Scoreboard bench for seg7_result_scanner with a
// slot-arithmetic reference model.
module tb_seg7_result_scanner;

    localparam int DIV = 8;
    localparam int BLK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data = '0;
    logic        zf = 1'b0;
    logic        of = 1'b0;
    logic        load = 1'b0;
    logic        freeze = 1'b0;
    logic        blz = 1'b0;
    logic        ack;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    seg7_result_scanner #(
        .REFRESH_DIV (DIV),
        .BLANK_CYC   (BLK)
    ) dut (
        .Clk      (clk),
        .Rst      (rst_n),
        .Data     (data),
        .ZF       (zf),
        .OF       (of),
        .Load     (load),
        .Freeze   (freeze),
        .Blank_Lz (blz),
        .Ack      (ack),
        .AN       (an),
        .SEG      (seg),
        .DP       (dp)
    );

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ack;
        bit         seg_any;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int errs = 0;
    int checks = 0;
    int cyc = 0;
    bit started = 0;

    // Reference state: elapsed ticks since reset plus captured values.
    int          tick = 0;
    logic [31:0] m_sh = '0;
    logic        m_zf = 1'b0;
    logic        m_of = 1'b0;

    logic [6:0] segtab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic exp_t predict();
        exp_t e;
        int pos;
        int slot;
        logic [31:0] upper;
        e.an = 8'hFF;
        e.seg = 7'h7F;
        e.dp = 1'b1;
        e.ack = 1'b0;
        e.seg_any = 0;
        e.cyc = cyc;
        if (rst_n) begin
            e.ack = load && !freeze;
            pos = tick % DIV;
            slot = (tick / DIV) % 8;
            upper = m_sh >> (4 * slot);
            if (pos >= BLK) begin
                if (blz && slot > 0 && upper == 0) begin
                    e.seg_any = 1;
                end else begin
                    e.an = ~(8'(1) << slot);
                    e.seg = segtab[upper % 16];
                    if (slot == 7) e.dp = ~m_of;
                    else if (slot == 6) e.dp = ~m_zf;
                end
            end
        end
        return e;
    endfunction

    task automatic drive(input logic r, input logic ld,
                         input logic [31:0] d, input logic z,
                         input logic o, input logic fr,
                         input logic bz);
        @(negedge clk);
        cyc++;
        rst_n = r;
        load = ld;
        data = d;
        zf = z;
        of = o;
        freeze = fr;
        blz = bz;
        q.push_back(predict());
        started = 1;
        if (r) begin
            if (ld && !fr) begin
                m_sh = d;
                m_zf = z;
                m_of = o;
            end
            tick++;
        end
    endtask

    task automatic idle(input int n, input logic bz);
        for (int i = 0; i < n; i++) drive(1, 0, 32'h0, 0, 0, 0, bz);
    endtask

    task automatic check1(input string nm, input logic [7:0] got,
                          input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    // Reset asserted between edges, away from any slot boundary.
    task automatic mid_reset();
        exp_t e;
        @(negedge clk);
        cyc++;
        load = 0;
        freeze = 0;
        e.an = 8'hFF;
        e.seg = 7'h7F;
        e.dp = 1'b1;
        e.ack = 1'b0;
        e.seg_any = 0;
        e.cyc = cyc;
        q.push_back(e);
        #2;
        rst_n = 0;
        #1;
        check1("rst_an", an, 8'hFF);
        check1("rst_seg", {1'b0, seg}, 8'h7F);
        check1("rst_dp", {7'b0, dp}, 8'h01);
        check1("rst_ack", {7'b0, ack}, 8'h00);
        tick = 0;
        m_sh = '0;
        m_zf = 0;
        m_of = 0;
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    // Monitor: pop one expectation per edge and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (q.size() == 0) begin
                    errs++;
                    checks++;
                    $display("FAIL queue_empty at time %0t", $time);
                end else begin
                    e = q.pop_front();
                    check1("an", an, e.an);
                    check1("dp", {7'b0, dp}, {7'b0, e.dp});
                    check1("ack", {7'b0, ack}, {7'b0, e.ack});
                    if (!e.seg_any) check1("seg", {1'b0, seg}, {1'b0, e.seg});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic ld;
        logic fr;
        logic [31:0] d;
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        idle(11, 0);
        mid_reset();
        idle(20, 0);
        drive(1, 1, 32'h12345678, 0, 1, 0, 0);
        idle(70, 0);
        for (int i = 0; i < 10; i++) drive(1, 1, 32'hFFFFFFFF, 1, 0, 1, 0);
        idle(20, 0);
        drive(1, 1, 32'hFFFFFFFF, 1, 0, 0, 0);
        idle(66, 0);
        drive(1, 1, 32'h000000A0, 1, 1, 0, 1);
        idle(66, 1);
        drive(1, 1, 32'h00000000, 1, 1, 0, 1);
        idle(66, 1);
        for (int k = 0; k < 8; k++) begin
            while (tick % DIV != DIV - 1) idle(1, 0);
            drive(1, 1, 32'h9ABCDEF0 ^ (32'h11111111 * k), k[0], k[1], 0, 0);
            idle(3, 0);
        end
        drive(1, 1, 32'hCAFE0123, 0, 0, 0, 0);
        drive(1, 1, 32'h0BADF00D, 1, 1, 0, 0);
        drive(1, 1, 32'h00F00000, 0, 1, 0, 1);
        idle(40, 1);
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) mid_reset();
            ld = ($urandom_range(0, 7) == 0);
            fr = ($urandom_range(0, 3) == 0);
            d = $urandom >> $urandom_range(0, 31);
            drive(1, ld, d, 1'($urandom), 1'($urandom), fr,
                  1'(i / 150 % 2));
        end
        idle(2, 0);
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
